// File: rtl/hash_job_scheduler.sv
// hash_job_scheduler: round-robin lane issue into a shared in-order MD5 pipeline, tag tracking and goal match.
// Define SCHED_ISSUE_LIMIT_EN to add a per-job issue limit (cfg_max_issue) and the exhausted flag.
module hash_job_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int TAG_DEPTH = 64,
  parameter int MSG_W = 448
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [127:0]                   cfg_h_goal,
`ifdef SCHED_ISSUE_LIMIT_EN
  input  logic [47:0]                    cfg_max_issue,
  output logic                           exhausted,
`endif
  input  logic [NUM_LANES-1:0]           lane_valid,
  input  logic [NUM_LANES*MSG_W-1:0]     lane_msg,
  output logic [NUM_LANES-1:0]           lane_ready,
  output logic                           md5_valid,
  output logic [MSG_W-1:0]               md5_msg,
  input  logic                           md5_res_valid,
  input  logic [127:0]                   md5_h_res,
  output logic                           busy,
  output logic                           found,
  output logic [$clog2(NUM_LANES)-1:0]   found_lane,
  output logic [47:0]                    issue_count
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [PW:0] inflight, inflight_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] tags [TAG_DEPTH];
  logic [LW-1:0] rr, gnt_id;
  logic [127:0] goal;
  logic gnt, can_issue, pop, match, limit_hit, stop;
`ifdef SCHED_ISSUE_LIMIT_EN
  logic [47:0] max_issue;
  assign limit_hit = (max_issue != 48'd0) && (issue_count == max_issue);
`else
  assign limit_hit = 1'b0;
`endif
  assign pop = md5_res_valid && (inflight != '0);
  assign match = pop && (state == RUN || state == DRAIN) && (md5_h_res == goal);
  assign stop = match || abort || limit_hit;
  // inflight never exceeds TAG_DEPTH, so its top bit alone means "full"
  assign can_issue = (state == RUN) && !inflight[PW] && !stop;
  // lowest offset from rr wins because it is assigned last
  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (lane_valid[rr + LW'(k)]) begin
        gnt = can_issue;
        gnt_id = rr + LW'(k);
      end
  end
  assign lane_ready = gnt ? (NUM_LANES'(1) << gnt_id) : '0;
  assign md5_valid = gnt;
  assign md5_msg = gnt ? lane_msg[gnt_id*MSG_W +: MSG_W] : '0;
  assign busy = (state == RUN) || (state == DRAIN);
  assign inflight_nx = inflight + (PW+1)'(gnt) - (PW+1)'(pop);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? (start ? RUN : IDLE) :
               (state == RUN)   ? (stop ? DRAIN : RUN) :
               (state == DRAIN) ? ((inflight_nx == '0) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk)
    if (gnt) tags[wr_ptr] <= gnt_id;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      inflight <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr <= '0;
      goal <= '0;
      found <= 1'b0;
      found_lane <= '0;
      issue_count <= '0;
    end else begin
      state <= state_nx;
      inflight <= inflight_nx;
      if (gnt) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr <= gnt_id + 1'b1;
        issue_count <= issue_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (match && !found) begin
        found <= 1'b1;
        found_lane <= tags[rd_ptr];
      end
      if (state == IDLE && start) begin
        goal <= cfg_h_goal;
        found <= 1'b0;
        found_lane <= '0;
        issue_count <= '0;
      end
    end
`ifdef SCHED_ISSUE_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      max_issue <= '0;
      exhausted <= 1'b0;
    end else if (state == IDLE && start) begin
      max_issue <= cfg_max_issue;
      exhausted <= 1'b0;
    end else if (state == DRAIN && state_nx == DONE) begin
      exhausted <= !(found || match);
    end
`endif
endmodule

// File: doc/hash_job_scheduler.md
HASH_JOB_SCHEDULER -- requirements
Module: hash_job_scheduler

Interface
REQ-001 Parameter NUM_LANES, default 4, number of candidate generator lanes (power of 2, 2..8).
REQ-002 Parameter TAG_DEPTH, default 64, maximum in-flight messages in the shared MD5 pipeline (power of 2).
REQ-003 Parameter MSG_W, default 448, candidate message width in bits.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a job; ignored outside IDLE.
REQ-007 abort  in  1  level; terminates a running job.
REQ-008 cfg_h_goal  in  128  target digest; sampled on accepted start.
REQ-009 lane_valid  in  NUM_LANES  lane i offers the message on lane_msg[i*MSG_W +: MSG_W].
REQ-010 lane_msg  in  NUM_LANES*MSG_W  candidate messages.
REQ-011 lane_ready  out  NUM_LANES  one-hot or zero; the lane message is consumed this cycle.
REQ-012 md5_valid  out  1  issue strobe to the MD5 pipeline.
REQ-013 md5_msg  out  MSG_W  message being issued.
REQ-014 md5_res_valid  in  1  pipeline result strobe; results return in issue order.
REQ-015 md5_h_res  in  128  digest accompanying md5_res_valid.
REQ-016 busy  out  1  high in RUN and DRAIN.
REQ-017 found  out  1  sticky success flag; cleared on next accepted start.
REQ-018 found_lane  out  log2(NUM_LANES)  lane that produced the matching message.
REQ-019 issue_count  out  48  messages issued in the current job.

Function
REQ-020 States: IDLE, RUN, DRAIN, DONE; reset state is IDLE.
REQ-021 IDLE->RUN on start; the same edge latches cfg_h_goal and clears found, found_lane, issue_count.
REQ-022 In RUN, each cycle the scheduler grants at most one lane via round-robin, searching from the lane after the last granted one.
REQ-023 A grant is issued only when in-flight count < TAG_DEPTH; lane_ready, md5_valid, and md5_msg are combinational with the grant (zero latency).
REQ-024 On grant: lane id pushed into the tag FIFO, in-flight incremented, issue_count incremented (wraps at 2^48).
REQ-025 On md5_res_valid: tag FIFO popped, in-flight decremented; simultaneous issue and result leave in-flight unchanged.
REQ-026 md5_res_valid with an empty tag FIFO is ignored; no pop, no match.
REQ-027 Match = md5_res_valid & (md5_h_res == latched goal) in RUN or DRAIN; the first match sets found and found_lane = popped tag; later matches do not overwrite.
REQ-028 RUN->DRAIN on match or on abort; issue stops the same cycle.
REQ-029 DRAIN->DONE when in-flight reaches 0, including when the last result arrives on the transition cycle.
REQ-030 DONE->IDLE after one cycle; found and found_lane hold until the next start.
REQ-031 abort in IDLE or DONE has no effect; start in RUN, DRAIN, or DONE is ignored.

Reset
REQ-032 rst_n low asynchronously forces IDLE, zeroes all outputs, the in-flight count, the tag FIFO pointers, and the round-robin pointer (lane 0 has first priority).
REQ-033 Reset mid-job discards in-flight tags; results arriving after reset are ignored per REQ-026.

Configuration
REQ-034 Macro SCHED_ISSUE_LIMIT_EN, when defined, adds input cfg_max_issue[47:0] (latched on start) and output exhausted (1 bit, reset 0).
REQ-035 With the macro defined, RUN->DRAIN occurs when issue_count reaches cfg_max_issue; exhausted sets if DONE is reached without found; cfg_max_issue=0 means unlimited.
REQ-036 Without the macro, neither port exists and issue is unlimited.

Verification
REQ-037 All 4 lanes valid for 8 cycles after start -> grants in order 0,1,2,3,0,1,2,3; issue_count=8.
REQ-038 TAG_DEPTH=64 with no results returned -> exactly 64 issues, then md5_valid stays 0 until one result returns, then 1 issue.
REQ-039 Only lane 2 valid; 10th result digest equals goal -> found=1, found_lane=2, DRAIN until in-flight=0, DONE, IDLE.
REQ-040 Abort asserted 5 cycles into RUN with 5 in flight -> no further issue; DONE after exactly 5 results; found=0.
REQ-041 rst_n pulsed low mid-RUN -> busy=0 and all outputs 0 immediately; a stray md5_res_valid afterward causes no state change.
REQ-042 With SCHED_ISSUE_LIMIT_EN defined and cfg_max_issue=3, no match -> 3 issues, exhausted=1 in DONE.
